uart_rx_param: RTL and testbench

Parametrised UART receiver, the next generation of the fixed 8-bit/1-parity receive path inside `UART`. It deserialises `SerialDataRx` using mid-bit sampling, with configurable word width, bit period, parity mode and stop-bit count. It reports per-word parity and framing errors and a sticky overrun flag. Received words are buffered in an optional receive FIFO and read by the host logic through a pop strobe.

---
 rtl/uart_rx_param.sv | 234 +++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with mid-bit sampling, parity and
// framing checks, sticky overrun flag and a receive buffer read by a pop strobe.
//
// Optional feature macro: UART_RX_FIFO_EN
//   defined   -> circular FIFO of FIFO_DEPTH entries {data, perr, ferr}
//   undefined -> single holding register (depth-1 buffer), FIFO_DEPTH unused
//
// Ports:
//   clk           system clock
//   reset         asynchronous active-low reset
//   SerialDataRx  serial line, idle high, asynchronous to clk
//   ReadData      pop strobe for the head word
//   ClearErrors   clears Overrun
//   ReceivedData  head word (holds last value when empty)
//   DataValid     head word present
//   ParityError   parity error flag of the head word
//   FramingError  framing error flag of the head word
//   Overrun       sticky: a received word was dropped
module uart_rx_param #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned PARITY_MODE  = 1,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  SerialDataRx,
  input  logic                  ReadData,
  input  logic                  ClearErrors,
  output logic [DATA_WIDTH-1:0] ReceivedData,
  output logic                  DataValid,
  output logic                  ParityError,
  output logic                  FramingError,
  output logic                  Overrun
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_WIDTH + 1);
  localparam int unsigned EW = DATA_WIDTH + 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  // Elaboration-time parameter sanity checks
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : gBadWidth
    $error("uart_rx_param: DATA_WIDTH must be 5..9");
  end
  if (CLKS_PER_BIT < 4) begin : gBadClks
    $error("uart_rx_param: CLKS_PER_BIT must be >= 4");
  end
  if (PARITY_MODE > 2) begin : gBadParity
    $error("uart_rx_param: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : gBadStop
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadDepth
    $error("uart_rx_param: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    sIdle, sStart, sData, sParity, sStop, sBrk
  } rxState_e;

  rxState_e              state;
  logic                  rxMeta, rxS;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         bitIdx;
  logic                  stopIdx;
  logic [DATA_WIDTH-1:0] shiftReg;
  logic                  perr, ferr;
  logic                  pushValid;
  logic [EW-1:0]         pushEntry;
  logic                  popC, acceptC, dropC;

  // 2-FF synchroniser, reset to line idle level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxMeta <= 1'b1;
      rxS    <= 1'b1;
    end else begin
      rxMeta <= SerialDataRx;
      rxS    <= rxMeta;
    end
  end

  // Receive FSM; emits a one-cycle push of {word, perr, ferr}
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= sIdle;
      cnt       <= '0;
      bitIdx    <= '0;
      stopIdx   <= 1'b0;
      shiftReg  <= '0;
      perr      <= 1'b0;
      ferr      <= 1'b0;
      pushValid <= 1'b0;
      pushEntry <= '0;
    end else begin
      pushValid <= 1'b0;
      cnt       <= cnt + CW'(1);
      case (state)
        sIdle: begin
          cnt <= '0;
          if (!rxS) state <= sStart;
        end
        sStart: begin
          // Half-period check; clearing cnt here re-phases later samples to mid-bit
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rxS) begin
              state   <= sData;
              bitIdx  <= '0;
              stopIdx <= 1'b0;
              perr    <= 1'b0;
              ferr    <= 1'b0;
            end else begin
              state <= sIdle;
            end
          end
        end
        sData: begin
          if (cnt == CNT_LAST) begin
            cnt      <= '0;
            shiftReg <= {rxS, shiftReg[DATA_WIDTH-1:1]};
            bitIdx   <= bitIdx + BW'(1);
            if (bitIdx == BIT_LAST) state <= (PARITY_MODE != 0) ? sParity : sStop;
          end
        end
        sParity: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            perr  <= (PARITY_MODE == 2) ? ~(^shiftReg ^ rxS) : (^shiftReg ^ rxS);
            state <= sStop;
          end
        end
        sStop: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (stopIdx == 1'(STOP_BITS - 1)) begin
              // Last stop sample: leave mid-bit so a back-to-back start is caught
              pushValid <= 1'b1;
              pushEntry <= {shiftReg, perr, ferr | ~rxS};
              state     <= (ferr | ~rxS) ? sBrk : sIdle;
            end else begin
              stopIdx <= 1'b1;
              ferr    <= ferr | ~rxS;
            end
          end
        end
        sBrk: begin
          cnt <= '0;
          if (rxS) state <= sIdle;
        end
        default: state <= sIdle;
      endcase
    end
  end

`ifdef UART_RX_FIFO_EN
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wrPtr, rdPtr, wrNext, rdNext;
  logic          fifoEmpty, fifoFull;
  logic [EW-1:0] headNext;

  // Pop is applied before push so a full FIFO accepts when read in the same cycle
  always_comb begin
    fifoEmpty = (wrPtr == rdPtr);
    fifoFull  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    popC      = ReadData & ~fifoEmpty;
    acceptC   = pushValid & (~fifoFull | popC);
    dropC     = pushValid & fifoFull & ~popC;
    rdNext    = rdPtr + (AW+1)'(popC);
    wrNext    = wrPtr + (AW+1)'(acceptC);
    // New head is the incoming word when the buffer is otherwise empty after the pop
    headNext  = (acceptC && (wrPtr[AW-1:0] == rdNext[AW-1:0])) ? pushEntry
                                                               : mem[rdNext[AW-1:0]];
  end

  // Storage array
  always_ff @(posedge clk) begin
    if (acceptC) mem[wrPtr[AW-1:0]] <= pushEntry;
  end

  // Pointers and registered head outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr        <= '0;
      rdPtr        <= '0;
      DataValid    <= 1'b0;
      ReceivedData <= '0;
      ParityError  <= 1'b0;
      FramingError <= 1'b0;
    end else begin
      wrPtr     <= wrNext;
      rdPtr     <= rdNext;
      DataValid <= (wrNext != rdNext);
      if (wrNext != rdNext) {ReceivedData, ParityError, FramingError} <= headNext;
    end
  end
`else
  // Depth-1 holding register with the same pop-before-push rule
  always_comb begin
    popC    = ReadData & DataValid;
    acceptC = pushValid & (~DataValid | popC);
    dropC   = pushValid & DataValid & ~popC;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      DataValid    <= 1'b0;
      ReceivedData <= '0;
      ParityError  <= 1'b0;
      FramingError <= 1'b0;
    end else if (acceptC) begin
      DataValid <= 1'b1;
      {ReceivedData, ParityError, FramingError} <= pushEntry;
    end else if (popC) begin
      DataValid <= 1'b0;
    end
  end
`endif

  // Sticky overrun; a new drop wins over a simultaneous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           Overrun <= 1'b0;
    else if (dropC)       Overrun <= 1'b1;
    else if (ClearErrors) Overrun <= 1'b0;
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed self-checking bench for uart_rx_param.
// Two slow instances (434 clk/bit, even and odd parity) share one line for the
// latency/parity checks; a fast instance (16 clk/bit, even) covers break,
// overrun, pop-before-push and mid-frame reset.
module tb_uart_rx_param;

`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  localparam int FAST_CPB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstS, lineS, rdS, clrS;
  logic [7:0] dataE, dataO;
  logic       dvE, peE, feE, ovE, dvO, peO, feO, ovO;
  logic       rstF, lineF, rdF, clrF;
  logic [7:0] dataF;
  logic       dvF, peF, feF, ovF;

  uart_rx_param #(.PARITY_MODE(1)) u0 (
    .clk(clk), .reset(rstS), .SerialDataRx(lineS), .ReadData(rdS), .ClearErrors(clrS),
    .ReceivedData(dataE), .DataValid(dvE), .ParityError(peE), .FramingError(feE), .Overrun(ovE)
  );

  uart_rx_param #(.PARITY_MODE(2)) u1 (
    .clk(clk), .reset(rstS), .SerialDataRx(lineS), .ReadData(rdS), .ClearErrors(clrS),
    .ReceivedData(dataO), .DataValid(dvO), .ParityError(peO), .FramingError(feO), .Overrun(ovO)
  );

  uart_rx_param #(.CLKS_PER_BIT(FAST_CPB), .PARITY_MODE(1), .FIFO_DEPTH(4)) uF (
    .clk(clk), .reset(rstF), .SerialDataRx(lineF), .ReadData(rdF), .ClearErrors(clrF),
    .ReceivedData(dataF), .DataValid(dvF), .ParityError(peF), .FramingError(feF), .Overrun(ovF)
  );

  int checks = 0;
  int fails  = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic driveLine(input bit fast, input logic v);
    if (fast) lineF = v;
    else      lineS = v;
  endtask

  // Start, 8 data bits LSB first, parity bit, one stop bit; called at a negedge
  task automatic sendFrame(input bit fast, input logic [7:0] d, input logic par, input int cpb);
    logic [10:0] bits;
    bits = {1'b1, par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      driveLine(fast, bits[i]);
      repeat (cpb) @(negedge clk);
    end
  endtask

  // Fast frame with correct even parity; optionally pulses ReadData so it is
  // sampled on edge readIdx after the start bit, and reports the first edge
  // on which DataValid is seen high.
  task automatic sendFast(input logic [7:0] d, input int readIdx, output int riseIdx);
    int rise;
    rise = 0;
    fork
      sendFrame(1'b1, d, ^d, FAST_CPB);
      begin
        for (int n = 1; n <= 200; n++) begin
          if (n == readIdx) rdF = 1'b1;
          @(posedge clk);
          @(negedge clk);
          rdF = 1'b0;
          if (dvF && rise == 0) rise = n;
        end
      end
    join
    riseIdx = rise;
  endtask

  task automatic popFast();
    rdF = 1'b1;
    @(negedge clk);
    rdF = 1'b0;
  endtask

  initial begin
    int n;
    int rise;
    int r;
    rstS = 1'b0; rstF = 1'b0;
    lineS = 1'b1; lineF = 1'b1;
    rdS = 1'b0; rdF = 1'b0; clrS = 1'b0; clrF = 1'b0;

    repeat (3) @(negedge clk);
    checkVal("rstData",    32'(dataE), 32'h0);
    checkVal("rstValid",   32'(dvE),   32'h0);
    checkVal("rstParity",  32'(peE),   32'h0);
    checkVal("rstFraming", 32'(feE),   32'h0);
    checkVal("rstOverrun", 32'(ovE),   32'h0);
    checkVal("rstValidF",  32'(dvF),   32'h0);
    rstS = 1'b1; rstF = 1'b1;
    repeat (5) @(negedge clk);

    // 0x55 with parity bit 1: even-parity error, odd-parity clean
    n = 0;
    fork
      sendFrame(1'b0, 8'h55, 1'b1, 434);
      begin
        while (!dvE && n < 6000) begin
          @(posedge clk);
          n++;
          @(negedge clk);
        end
      end
    join
    checkVal("latencyWindow", 32'((n - 1) >= 4557 && (n - 1) <= 4561), 32'h1);
    checkVal("evenData",    32'(dataE), 32'h55);
    checkVal("evenParity",  32'(peE),   32'h1);
    checkVal("evenFraming", 32'(feE),   32'h0);
    checkVal("oddValid",    32'(dvO),   32'h1);
    checkVal("oddData",     32'(dataO), 32'h55);
    checkVal("oddParity",   32'(peO),   32'h0);
    rdS = 1'b1;
    @(negedge clk);
    rdS = 1'b0;
    checkVal("evenPopValid", 32'(dvE), 32'h0);
    checkVal("oddPopValid",  32'(dvO), 32'h0);

    // 100-cycle glitch must be rejected, then a real frame still decodes
    lineS = 1'b0;
    repeat (100) @(negedge clk);
    lineS = 1'b1;
    repeat (700) @(negedge clk);
    checkVal("glitchValidE", 32'(dvE), 32'h0);
    checkVal("glitchValidO", 32'(dvO), 32'h0);
    sendFrame(1'b0, 8'hC4, 1'b1, 434);
    checkVal("afterGlitchData",    32'(dataE), 32'hC4);
    checkVal("afterGlitchParityE", 32'(peE),   32'h0);
    checkVal("afterGlitchParityO", 32'(peO),   32'h1);
    rdS = 1'b1;
    @(negedge clk);
    rdS = 1'b0;

    // Break: 20 bit periods low yields exactly one 0x00 framing-error word
    lineF = 1'b0;
    repeat (20 * FAST_CPB) @(negedge clk);
    lineF = 1'b1;
    repeat (2 * FAST_CPB) @(negedge clk);
    checkVal("brkValid",   32'(dvF),   32'h1);
    checkVal("brkData",    32'(dataF), 32'h0);
    checkVal("brkFraming", 32'(feF),   32'h1);
    checkVal("brkParity",  32'(peF),   32'h0);
    popFast();
    repeat (40) @(negedge clk);
    checkVal("brkSingleWord", 32'(dvF), 32'h0);
    sendFrame(1'b1, 8'hA3, 1'b0, FAST_CPB);
    repeat (4) @(negedge clk);
    checkVal("a3Data",    32'(dataF), 32'hA3);
    checkVal("a3Parity",  32'(peF),   32'h0);
    checkVal("a3Framing", 32'(feF),   32'h0);
    popFast();

    // Overflow by one word with no reads
    for (int i = 1; i <= DEPTH + 1; i++) sendFast(8'(i), 0, r);
    repeat (8) @(negedge clk);
    checkVal("ovfSet", 32'(ovF), 32'h1);
    for (int i = 1; i <= DEPTH; i++) begin
      checkVal($sformatf("ovfPop%0d", i), 32'(dataF), 32'(i));
      popFast();
    end
    checkVal("ovfEmpty", 32'(dvF), 32'h0);
    clrF = 1'b1;
    @(negedge clk);
    clrF = 1'b0;
    checkVal("ovfCleared", 32'(ovF), 32'h0);

    // Same, but a pop coincides with the last push: no overrun
    sendFast(8'h01, 0, rise);
    for (int i = 2; i <= DEPTH; i++) sendFast(8'(i), 0, r);
    sendFast(8'(DEPTH + 1), rise, r);
    repeat (8) @(negedge clk);
    checkVal("coPopNoOvf", 32'(ovF), 32'h0);
    for (int i = 2; i <= DEPTH + 1; i++) begin
      checkVal($sformatf("coPop%0d", i), 32'(dataF), 32'(i));
      popFast();
    end
    checkVal("coPopEmpty", 32'(dvF), 32'h0);

    // Reset during DATA with a word already buffered
    sendFrame(1'b1, 8'h11, 1'b0, FAST_CPB);
    repeat (4) @(negedge clk);
    checkVal("preRstValid", 32'(dvF), 32'h1);
    lineF = 1'b0;
    repeat (56) @(negedge clk);
    rstF  = 1'b0;
    lineF = 1'b1;
    repeat (2) @(negedge clk);
    checkVal("midRstValid",   32'(dvF),   32'h0);
    checkVal("midRstData",    32'(dataF), 32'h0);
    checkVal("midRstParity",  32'(peF),   32'h0);
    checkVal("midRstFraming", 32'(feF),   32'h0);
    checkVal("midRstOverrun", 32'(ovF),   32'h0);
    rstF = 1'b1;
    repeat (12 * FAST_CPB) @(negedge clk);
    checkVal("postRstNoPush", 32'(dvF), 32'h0);
    sendFrame(1'b1, 8'h3C, 1'b0, FAST_CPB);
    repeat (4) @(negedge clk);
    checkVal("postRstValid",   32'(dvF),   32'h1);
    checkVal("postRstData",    32'(dataF), 32'h3C);
    checkVal("postRstParity",  32'(peF),   32'h0);
    checkVal("postRstFraming", 32'(feF),   32'h0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
